// File: rtl/mmio_host_pkg.sv
// mmio_host_pkg: shared enums and default widths for the MMIO host master
`ifndef MMIO_ADDR_WIDTH
`define MMIO_ADDR_WIDTH 16
`endif
`ifndef HOST_DATA_WIDTH
`define HOST_DATA_WIDTH 32
`endif
package mmio_host_pkg;
  typedef enum logic [1:0] {OP_WRITE = 2'b00, OP_READ = 2'b01, OP_POLL = 2'b10, OP_RSVD = 2'b11} op_e;
  typedef enum logic [1:0] {ST_OK = 2'b00, ST_TIMEOUT = 2'b01, ST_BAD_OP = 2'b10} status_e;
  typedef enum logic [2:0] {IDLE, WRITE, RD_WAIT, POLL_WAIT, RESP} state_e;
endpackage

// File: rtl/mmio_host_master.sv
// mmio_host_master: command-stream initiator driving WRITE/READ/POLL cycles on the NPU MMIO port
module mmio_host_master
  import mmio_host_pkg::*;
#(
  parameter int ADDR_W = `MMIO_ADDR_WIDTH,
  parameter int DATA_W = `HOST_DATA_WIDTH,
  parameter int RD_LAT = 1,
  parameter int TMO_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [DATA_W-1:0] cmd_mask,
  input  logic [TMO_W-1:0]  cmd_tmo,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_status,
  output logic [ADDR_W-1:0] host_addr,
  output logic [DATA_W-1:0] host_wr_data,
  output logic              host_wr_en,
  input  logic [DATA_W-1:0] host_rd_data,
  output logic              busy
);
  localparam int LW = RD_LAT > 0 ? $clog2(RD_LAT + 1) : 1;
  state_e            state_q;
  status_e           status_q;
  logic [LW-1:0]     lat_q;
  logic [TMO_W-1:0]  att_q, tmo_q, att_d;
  logic [DATA_W-1:0] data_q, mask_q, rsp_data_q, wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic              lat_done, hit, tmo_hit;
  // attempt count saturates so an unbounded poll can never wrap into a timeout
  assign att_d    = &att_q ? att_q : att_q + 1'b1;
  assign lat_done = lat_q == LW'(RD_LAT);
  assign hit      = ((host_rd_data ^ data_q) & mask_q) == '0;
  assign tmo_hit  = tmo_q != '0 && att_d == tmo_q;
  assign cmd_ready    = state_q == IDLE && !rst;
  assign busy         = state_q != IDLE;
  assign rsp_valid    = state_q == RESP;
  assign host_wr_en   = state_q == WRITE;
  assign host_addr    = addr_q;
  assign host_wr_data = wdata_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_status   = status_q;
  // command FSM: accept, run the MMIO cycle(s), hold the response until consumed
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      status_q   <= ST_OK;
      lat_q      <= '0;
      att_q      <= '0;
      tmo_q      <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      rsp_data_q <= '0;
      wdata_q    <= '0;
      addr_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          data_q <= cmd_data;
          mask_q <= cmd_mask;
          tmo_q  <= cmd_tmo;
          att_q  <= '0;
          lat_q  <= '0;
          if (op_e'(cmd_op) == OP_RSVD) begin
            status_q   <= ST_BAD_OP;
            rsp_data_q <= '0;
            state_q    <= RESP;
          end else begin
            addr_q  <= cmd_addr;
            wdata_q <= op_e'(cmd_op) == OP_WRITE ? cmd_data : wdata_q;
            state_q <= op_e'(cmd_op) == OP_WRITE ? WRITE : op_e'(cmd_op) == OP_READ ? RD_WAIT : POLL_WAIT;
          end
        end
        WRITE: begin
          rsp_data_q <= data_q;
          status_q   <= ST_OK;
          state_q    <= RESP;
        end
        RD_WAIT: if (lat_done) begin
          rsp_data_q <= host_rd_data;
          status_q   <= ST_OK;
          state_q    <= RESP;
        end else lat_q <= lat_q + 1'b1;
        POLL_WAIT: if (lat_done) begin
          rsp_data_q <= host_rd_data;
          att_q      <= att_d;
          lat_q      <= '0;
          status_q   <= hit ? ST_OK : ST_TIMEOUT;
          state_q    <= hit || tmo_hit ? RESP : POLL_WAIT;
        end else lat_q <= lat_q + 1'b1;
        RESP: if (rsp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mmio_host_master.sv
// tb_mmio_host_master: three DUTs (RD_LAT 0/1/3) with register-file responders and a memory model
module tb_mmio_host_master;
  logic              clk = 0;
  logic              rst = 1;
  logic [2:0]        cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0, host_wr_en, busy, poke_en = 0;
  logic [1:0]        cmd_op = 0;
  logic [7:0]        cmd_addr = 0, poke_addr = 0;
  logic [31:0]       cmd_data = 0, cmd_mask = 0, poke_data = 0;
  logic [15:0]       cmd_tmo = 0;
  logic [31:0]       rsp_data [3];
  logic [1:0]        rsp_status [3];
  logic [7:0]        host_addr [3];
  logic [31:0]       host_wr_data [3], host_rd_data [3];
  int                wr_cnt [3];
  logic [7:0]        last_wa [3];
  logic [31:0]       last_wd [3];
  logic [31:0]       model [3][256];
  int                n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = g == 0 ? 0 : g == 1 ? 1 : 3;
    logic [31:0] mem [256];
    logic [31:0] pipe [4];
    int          wc = 0;
    logic [7:0]  wa = 0;
    logic [31:0] wd = 0;
    mmio_host_master #(.ADDR_W(8), .DATA_W(32), .RD_LAT(L), .TMO_W(16)) u_dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
      .cmd_data(cmd_data), .cmd_mask(cmd_mask), .cmd_tmo(cmd_tmo),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_data(rsp_data[g]), .rsp_status(rsp_status[g]),
      .host_addr(host_addr[g]), .host_wr_data(host_wr_data[g]), .host_wr_en(host_wr_en[g]),
      .host_rd_data(host_rd_data[g]), .busy(busy[g])
    );
    initial for (int i = 0; i < 256; i++) mem[i] = 0;
    always @(posedge clk) begin
      if (host_wr_en[g]) begin
        mem[host_addr[g]] <= host_wr_data[g];
        wc <= wc + 1;
        wa <= host_addr[g];
        wd <= host_wr_data[g];
      end else if (poke_en[g]) mem[poke_addr] <= poke_data;
      pipe[0] <= mem[host_addr[g]];
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign host_rd_data[g] = L == 0 ? mem[host_addr[g]] : pipe[L == 0 ? 0 : L - 1];
    assign wr_cnt[g]  = wc;
    assign last_wa[g] = wa;
    assign last_wd[g] = wd;
  end

  function automatic int lat_of(input int k);
    return k == 0 ? 0 : k == 1 ? 1 : 3;
  endfunction

  task automatic run_cmd(input int k, input logic [1:0] op, input logic [7:0] a, input logic [31:0] d, m,
                         input logic [15:0] t, input int hold, output logic [31:0] rd, output logic [1:0] rs,
                         output int lat, output int wrs, output bit unstable, output bit rdy_after, output bit tmo);
    int n, w0;
    tmo = 0; unstable = 0; lat = 0; wrs = 0; rdy_after = 0; rd = 'x; rs = 'x;
    @(negedge clk);
    cmd_op = op; cmd_addr = a; cmd_data = d; cmd_mask = m; cmd_tmo = t; cmd_valid[k] = 1;
    n = 0;
    while (!cmd_ready[k] && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready[k]) begin tmo = 1; cmd_valid[k] = 0; return; end
    w0 = wr_cnt[k];
    @(negedge clk);
    cmd_valid[k] = 0;
    lat = 1;
    while (!rsp_valid[k] && lat < 2000) begin @(negedge clk); lat++; end
    if (!rsp_valid[k]) begin tmo = 1; return; end
    rd = rsp_data[k]; rs = rsp_status[k];
    repeat (hold) begin
      @(negedge clk);
      if (!rsp_valid[k] || rsp_data[k] !== rd || rsp_status[k] !== rs || cmd_ready[k]) unstable = 1;
    end
    rsp_ready[k] = 1;
    @(negedge clk);
    rsp_ready[k] = 0;
    rdy_after = cmd_ready[k];
    wrs = wr_cnt[k] - w0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (cmd_ready[k] !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_ready[%0d] got %b want 0", k, cmd_ready[k]); end
      n_cmp++; if ({rsp_valid[k], host_wr_en[k], busy[k]} !== 3'b000) begin n_bad++; $display("FAIL reset_flags[%0d] got %b want 000", k, {rsp_valid[k], host_wr_en[k], busy[k]}); end
      n_cmp++; if ({rsp_data[k], rsp_status[k], host_addr[k], host_wr_data[k]} !== '0) begin n_bad++; $display("FAIL reset_regs[%0d] got %h/%h/%h/%h want 0", k, rsp_data[k], rsp_status[k], host_addr[k], host_wr_data[k]); end
    end
    rst = 0;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 3'b111) begin n_bad++; $display("FAIL reset_release_ready got %b want 111", cmd_ready); end
  endtask

  task automatic test_write;
    logic [31:0] rd; logic [1:0] rs; int lat, wrs; bit un, ra, to;
    for (int k = 0; k < 3; k++) begin
      run_cmd(k, 2'b00, 8'h04, 32'hDEADBEEF, 0, 0, 0, rd, rs, lat, wrs, un, ra, to);
      model[k][4] = 32'hDEADBEEF;
      n_cmp++; if (to) begin n_bad++; $display("FAIL write_timeout[%0d] got stuck want response", k); end
      n_cmp++; if (rd !== 32'hDEADBEEF || rs !== 2'b00) begin n_bad++; $display("FAIL write_rsp[%0d] got %h/%b want deadbeef/00", k, rd, rs); end
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL write_lat[%0d] got %0d want 2", k, lat); end
      n_cmp++; if (wrs !== 1 || last_wa[k] !== 8'h04 || last_wd[k] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL write_strobe[%0d] got %0d pulses @%h=%h want 1 @04=deadbeef", k, wrs, last_wa[k], last_wd[k]); end
      n_cmp++; if (ra !== 1'b1) begin n_bad++; $display("FAIL write_ready_after[%0d] got %b want 1", k, ra); end
    end
  endtask

  task automatic test_read;
    logic [31:0] rd; logic [1:0] rs; int lat, wrs; bit un, ra, to;
    for (int k = 0; k < 3; k++) begin
      run_cmd(k, 2'b01, 8'h04, 0, 0, 0, 0, rd, rs, lat, wrs, un, ra, to);
      n_cmp++; if (to || rd !== model[k][4] || rs !== 2'b00) begin n_bad++; $display("FAIL read_rsp[%0d] got %h/%b to=%b want %h/00", k, rd, rs, to, model[k][4]); end
      n_cmp++; if (lat !== lat_of(k) + 2) begin n_bad++; $display("FAIL read_lat[%0d] got %0d want %0d", k, lat, lat_of(k) + 2); end
      n_cmp++; if (wrs !== 0) begin n_bad++; $display("FAIL read_no_write[%0d] got %0d want 0", k, wrs); end
    end
  endtask

  task automatic test_poll;
    logic [31:0] rd; logic [1:0] rs; int lat, wrs; bit un, ra, to;
    fork
      begin
        repeat (20) @(negedge clk);
        poke_addr = 8'h08; poke_data = 32'hA5A50001; poke_en[1] = 1;
        model[1][8] = 32'hA5A50001;
        @(negedge clk);
        poke_en[1] = 0;
      end
      run_cmd(1, 2'b10, 8'h08, 32'h1, 32'h1, 0, 0, rd, rs, lat, wrs, un, ra, to);
    join
    n_cmp++; if (to || rs !== 2'b00 || rd !== 32'hA5A50001) begin n_bad++; $display("FAIL poll_rsp got %h/%b to=%b want a5a50001/00", rd, rs, to); end
    n_cmp++; if (lat < 20 || (lat - 1) % 2 != 0) begin n_bad++; $display("FAIL poll_lat got %0d want >=20 and N*2+1", lat); end
    n_cmp++; if (wrs !== 0) begin n_bad++; $display("FAIL poll_no_write got %0d want 0", wrs); end
  endtask

  task automatic test_timeout;
    logic [31:0] rd; logic [1:0] rs; int lat, wrs; bit un, ra, to;
    run_cmd(2, 2'b10, 8'h10, 32'h5, 32'hF, 16'd5, 0, rd, rs, lat, wrs, un, ra, to);
    n_cmp++; if (to || rs !== 2'b01 || rd !== model[2][8'h10]) begin n_bad++; $display("FAIL timeout_rsp got %h/%b to=%b want %h/01", rd, rs, to, model[2][8'h10]); end
    n_cmp++; if (lat !== 5 * 4 + 1) begin n_bad++; $display("FAIL timeout_reads got lat %0d want 21 (5 reads)", lat); end
    n_cmp++; if (wrs !== 0) begin n_bad++; $display("FAIL timeout_no_write got %0d want 0", wrs); end
  endtask

  task automatic test_bad_op;
    logic [31:0] rd; logic [1:0] rs; int lat, wrs; bit un, ra, to;
    logic [7:0] a0;
    a0 = host_addr[0];
    run_cmd(0, 2'b11, 8'h33, 32'h12345678, 0, 0, 10, rd, rs, lat, wrs, un, ra, to);
    n_cmp++; if (to || rs !== 2'b10 || rd !== 32'h0) begin n_bad++; $display("FAIL badop_rsp got %h/%b to=%b want 0/10", rd, rs, to); end
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL badop_lat got %0d want 1", lat); end
    n_cmp++; if (un) begin n_bad++; $display("FAIL badop_hold got unstable want stable with cmd_ready=0"); end
    n_cmp++; if (wrs !== 0 || host_addr[0] !== a0) begin n_bad++; $display("FAIL badop_no_mmio got %0d writes addr %h want 0 writes addr %h", wrs, host_addr[0], a0); end
    n_cmp++; if (ra !== 1'b1) begin n_bad++; $display("FAIL badop_ready_after got %b want 1", ra); end
  endtask

  task automatic test_reset_mid_write;
    logic [31:0] rd; logic [1:0] rs; int lat, wrs, w0; bit un, ra, to;
    w0 = wr_cnt[1];
    @(negedge clk);
    cmd_op = 2'b00; cmd_addr = 8'h04; cmd_data = 32'h12345678; cmd_valid[1] = 1;
    @(negedge clk);
    cmd_valid[1] = 0;
    n_cmp++; if (host_wr_en[1] !== 1'b1 || host_addr[1] !== 8'h04) begin n_bad++; $display("FAIL midrst_strobe got en=%b addr=%h want 1/04", host_wr_en[1], host_addr[1]); end
    rst = 1;
    #1;
    n_cmp++; if (host_wr_en[1] !== 1'b0 || busy[1] !== 1'b0) begin n_bad++; $display("FAIL midrst_async got en=%b busy=%b want 0/0", host_wr_en[1], busy[1]); end
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rsp_valid[1] !== 1'b0 || wr_cnt[1] !== w0) begin n_bad++; $display("FAIL midrst_discard got valid=%b writes=%0d want 0/%0d", rsp_valid[1], wr_cnt[1], w0); end
    run_cmd(1, 2'b01, 8'h04, 0, 0, 0, 0, rd, rs, lat, wrs, un, ra, to);
    n_cmp++; if (to || rd !== model[1][4] || rs !== 2'b00 || lat !== 3) begin n_bad++; $display("FAIL midrst_read got %h/%b lat %0d want %h/00 lat 3", rd, rs, lat, model[1][4]); end
  endtask

  task automatic test_random;
    logic [31:0] rd, d, m, ed; logic [1:0] rs, es; int lat, wrs, el, ew, k, sel; bit un, ra, to;
    logic [7:0] a; logic [15:0] t; logic [1:0] op;
    for (int it = 0; it < 80; it++) begin
      k = $urandom_range(0, 2); sel = $urandom_range(0, 9); a = 8'($urandom_range(0, 15));
      d = $urandom; m = $urandom; t = 16'($urandom_range(1, 4));
      if (sel >= 6 && sel <= 8 && $urandom_range(0, 1) == 1) d = model[k][a];
      op = sel < 3 ? 2'b00 : sel < 6 ? 2'b01 : sel < 9 ? 2'b10 : 2'b11;
      ew = 0; es = 2'b00; ed = model[k][a]; el = lat_of(k) + 2;
      if (op == 2'b00) begin ed = d; el = 2; ew = 1; end
      else if (op == 2'b10 && ((model[k][a] ^ d) & m) != 0) begin es = 2'b01; el = int'(t) * (lat_of(k) + 1) + 1; end
      else if (op == 2'b11) begin ed = 0; es = 2'b10; el = 1; end
      run_cmd(k, op, a, d, m, op == 2'b10 ? t : 16'($urandom), $urandom_range(0, 3), rd, rs, lat, wrs, un, ra, to);
      if (op == 2'b00) model[k][a] = d;
      n_cmp++; if (to || rd !== ed || rs !== es) begin n_bad++; $display("FAIL rand%0d_rsp k=%0d op=%0d got %h/%b to=%b want %h/%b", it, k, op, rd, rs, to, ed, es); end
      n_cmp++; if (lat !== el || wrs !== ew) begin n_bad++; $display("FAIL rand%0d_timing k=%0d op=%0d got lat %0d wr %0d want lat %0d wr %0d", it, k, op, lat, wrs, el, ew); end
      n_cmp++; if (un || !ra) begin n_bad++; $display("FAIL rand%0d_hs k=%0d got unstable=%b ready_after=%b want 0/1", it, k, un, ra); end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) for (int i = 0; i < 256; i++) model[k][i] = 0;
    test_reset;
    test_write;
    test_read;
    test_poll;
    test_timeout;
    test_bad_op;
    test_reset_mid_write;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got no finish want finish before 400000ns");
    $fatal(1, "watchdog");
  end
endmodule
